draw_score: RTL and testbench



---
 rtl/draw_score_pkg.sv | 38 +++
 rtl/score_digit_rom.sv | 28 ++
 rtl/draw_score.sv | 147 ++++++++++++++
 tb/tb_draw_score.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/draw_score_pkg.sv
// rtl/draw_score_pkg.sv - shared constants and BCD helpers for the score overlay
package draw_score_pkg;

  localparam int CELL_W = 16;
  localparam int CELL_H = 32;
  localparam int DIGITS = 4;
  localparam int BOX_W  = CELL_W * DIGITS;
  localparam int BOX_H  = CELL_H;
  localparam int BCD_W  = 4;

  localparam logic [11:0] COLOR_BLACK = 12'h000;
  localparam logic [11:0] COLOR_WHITE = 12'hfff;

  function automatic logic [DIGITS*BCD_W-1:0] to_bcd(input int n);
    return {4'((n / 1000) % 10), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  // Decimal +1 with carry ripple; holds once the saturation value is reached.
  function automatic logic [DIGITS*BCD_W-1:0] bcd_inc(input logic [DIGITS*BCD_W-1:0] v,
                                                      input logic [DIGITS*BCD_W-1:0] max_bcd);
    logic [DIGITS*BCD_W-1:0] r;
    logic                    carry;
    r     = v;
    carry = (v != max_bcd);
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (r[i*BCD_W +: BCD_W] == 4'd9) begin
          r[i*BCD_W +: BCD_W] = '0;
        end else begin
          r[i*BCD_W +: BCD_W] = r[i*BCD_W +: BCD_W] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/score_digit_rom.sv
// rtl/score_digit_rom.sv - 8x16 glyph rows for decimal digits 0-9
module score_digit_rom (
  input  logic [3:0] digit,
  input  logic [3:0] row,
  output logic [7:0] row_bits
);

  logic [127:0] glyph;

  // Each constant is 16 row bytes, row 0 in the top byte, bit 7 leftmost.
  always_comb begin
    case (digit)
      4'd0:    glyph = 128'h00007CC6C6CEDEF6E6C6C6C67C000000;
      4'd1:    glyph = 128'h0000183878181818181818187E000000;
      4'd2:    glyph = 128'h00007CC6060C183060C0C0C6FE000000;
      4'd3:    glyph = 128'h00007CC606063C0606060606C67C0000;
      4'd4:    glyph = 128'h00000C1C3C6CCCFE0C0C0C0C1E000000;
      4'd5:    glyph = 128'h0000FEC0C0C0FC0606060606C67C0000;
      4'd6:    glyph = 128'h00003860C0C0FCC6C6C6C6C67C000000;
      4'd7:    glyph = 128'h0000FEC606060C183030303030000000;
      4'd8:    glyph = 128'h00007CC6C6C67CC6C6C6C6C67C000000;
      4'd9:    glyph = 128'h00007CC6C6C67E0606060606C0C78000;
      default: glyph = '0;
    endcase
    row_bits = glyph[{4'd15 - row, 3'b000} +: 8];
  end

endmodule

// File: rtl/draw_score.sv
// rtl/draw_score.sv - BCD score counter and 2-cycle glyph overlay on the VGA stream
module draw_score
  import draw_score_pkg::*;
#(
  parameter int          SCORE_X_POS = 16,
  parameter int          SCORE_Y_POS = 16,
  parameter logic [11:0] DIGIT_COLOR = COLOR_WHITE,
  parameter int          SCORE_MAX   = 9999
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic        hsync_in,
  input  logic        hblnk_in,
  input  logic [10:0] vcount_in,
  input  logic        vsync_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic        food_eaten,
  input  logic        new_game,
  output logic [10:0] hcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic [10:0] vcount_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out,
  output logic [15:0] score_bcd
);

  localparam logic [15:0] MAX_BCD = to_bcd(SCORE_MAX);
  localparam logic [10:0] X0 = 11'(SCORE_X_POS);
  localparam logic [10:0] X1 = 11'(SCORE_X_POS + BOX_W);
  localparam logic [10:0] Y0 = 11'(SCORE_Y_POS);
  localparam logic [10:0] Y1 = 11'(SCORE_Y_POS + BOX_H);

  logic [15:0] shown_bcd;
  logic        vsync_prev;

  always_ff @(posedge pclk) begin
    if (rst) begin
      score_bcd  <= '0;
      shown_bcd  <= '0;
      vsync_prev <= 1'b0;
    end else begin
      vsync_prev <= vsync_in;
      // Latch only at frame start so a score change never tears mid-frame.
      if (vsync_in && !vsync_prev) shown_bcd <= score_bcd;
      if (new_game)        score_bcd <= '0;
      else if (food_eaten) score_bcd <= bcd_inc(score_bcd, MAX_BCD);
    end
  end

  logic       in_box;
  logic [1:0] digit_idx;
  logic [2:0] col;
  logic [3:0] row;
  logic [3:0] digit_val;
  logic [3:0] lead;
  logic       digit_vis;
  logic [7:0] rom_bits;

  always_comb begin
    in_box    = (hcount_in >= X0) && (hcount_in < X1) && (vcount_in >= Y0) && (vcount_in < Y1);
    digit_idx = '0;
    col       = '0;
    row       = '0;
    if (in_box) begin
      digit_idx = 2'((hcount_in - X0) >> 4);
      col       = 3'((hcount_in - X0) >> 1);
      row       = 4'((vcount_in - Y0) >> 1);
    end
    // lead[i]: some digit at or left of cell i is non-zero; units always drawn.
    lead[0] = (shown_bcd[15:12] != 4'd0);
    lead[1] = lead[0] || (shown_bcd[11:8] != 4'd0);
    lead[2] = lead[1] || (shown_bcd[7:4] != 4'd0);
    lead[3] = 1'b1;
    digit_vis = lead[digit_idx];
    case (digit_idx)
      2'd0:    digit_val = shown_bcd[15:12];
      2'd1:    digit_val = shown_bcd[11:8];
      2'd2:    digit_val = shown_bcd[7:4];
      default: digit_val = shown_bcd[3:0];
    endcase
  end

  score_digit_rom u_rom (
    .digit    (digit_val),
    .row      (row),
    .row_bits (rom_bits)
  );

  logic [10:0] hcount_s1, vcount_s1;
  logic        hsync_s1, hblnk_s1, vsync_s1, vblnk_s1;
  logic [11:0] rgb_s1;
  logic        in_box_s1, vis_s1;
  logic [2:0]  col_s1;
  logic [7:0]  glyph_s1;

  always_ff @(posedge pclk) begin
    if (rst) begin
      hcount_s1  <= '0;
      hsync_s1   <= 1'b0;
      hblnk_s1   <= 1'b0;
      vcount_s1  <= '0;
      vsync_s1   <= 1'b0;
      vblnk_s1   <= 1'b0;
      rgb_s1     <= '0;
      in_box_s1  <= 1'b0;
      vis_s1     <= 1'b0;
      col_s1     <= '0;
      glyph_s1   <= '0;
      hcount_out <= '0;
      hsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vcount_out <= '0;
      vsync_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_s1  <= hcount_in;
      hsync_s1   <= hsync_in;
      hblnk_s1   <= hblnk_in;
      vcount_s1  <= vcount_in;
      vsync_s1   <= vsync_in;
      vblnk_s1   <= vblnk_in;
      rgb_s1     <= rgb_in;
      in_box_s1  <= in_box;
      vis_s1     <= digit_vis;
      col_s1     <= col;
      glyph_s1   <= rom_bits;
      hcount_out <= hcount_s1;
      hsync_out  <= hsync_s1;
      hblnk_out  <= hblnk_s1;
      vcount_out <= vcount_s1;
      vsync_out  <= vsync_s1;
      vblnk_out  <= vblnk_s1;
      if (hblnk_s1 || vblnk_s1)
        rgb_out <= COLOR_BLACK;
      else if (in_box_s1 && vis_s1 && glyph_s1[3'd7 - col_s1])
        rgb_out <= DIGIT_COLOR;
      else
        rgb_out <= rgb_s1;
    end
  end

endmodule

// File: tb/tb_draw_score.sv
// tb/tb_draw_score.sv - scoreboard bench for draw_score
module tb_draw_score;

  localparam int X = 16;
  localparam int Y = 16;

  logic        pclk = 1'b0;
  logic        rst;
  logic [10:0] hcount_in, vcount_in, hcount_out, vcount_out;
  logic        hsync_in, hblnk_in, vsync_in, vblnk_in;
  logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
  logic [11:0] rgb_in, rgb_out;
  logic        food_eaten, new_game;
  logic [15:0] score_bcd;

  always #5 pclk = ~pclk;

  draw_score dut (
    .pclk       (pclk),
    .rst        (rst),
    .hcount_in  (hcount_in),
    .hsync_in   (hsync_in),
    .hblnk_in   (hblnk_in),
    .vcount_in  (vcount_in),
    .vsync_in   (vsync_in),
    .vblnk_in   (vblnk_in),
    .rgb_in     (rgb_in),
    .food_eaten (food_eaten),
    .new_game   (new_game),
    .hcount_out (hcount_out),
    .hsync_out  (hsync_out),
    .hblnk_out  (hblnk_out),
    .vcount_out (vcount_out),
    .vsync_out  (vsync_out),
    .vblnk_out  (vblnk_out),
    .rgb_out    (rgb_out),
    .score_bcd  (score_bcd)
  );

  int           errors = 0;
  int           checks = 0;
  logic [37:0]  exp_q[$];
  int           score_dec;
  logic [15:0]  shown_m;
  logic         vprev_m;
  logic [127:0] font [10];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] bcd_of(input int n);
    return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  function automatic logic [37:0] model(input logic [10:0] h, input logic hs, input logic hb,
                                        input logic [10:0] v, input logic vs, input logic vb,
                                        input logic [11:0] rgb);
    logic [11:0] px;
    int dx, dy, d, nib;
    bit vis;
    px = rgb;
    if (hb || vb) begin
      px = 12'h000;
    end else if (int'(h) >= X && int'(h) < X + 64 && int'(v) >= Y && int'(v) < Y + 32) begin
      dx  = int'(h) - X;
      dy  = int'(v) - Y;
      d   = dx / 16;
      nib = int'((shown_m >> (4 * (3 - d))) & 16'hf);
      vis = (d == 3);
      for (int k = 0; k <= d; k++)
        if (((shown_m >> (4 * (3 - k))) & 16'hf) != 0) vis = 1;
      if (vis && font[nib][127 - 8 * (dy / 2) - (dx % 16) / 2]) px = 12'hfff;
    end
    return {h, hs, hb, v, vs, vb, px};
  endfunction

  task automatic step(input logic r, input logic [10:0] h, input logic hs, input logic hb,
                      input logic [10:0] v, input logic vs, input logic vb,
                      input logic [11:0] rgb, input logic fe, input logic ng);
    logic [37:0] e;
    @(negedge pclk);
    rst = r; hcount_in = h; hsync_in = hs; hblnk_in = hb;
    vcount_in = v; vsync_in = vs; vblnk_in = vb; rgb_in = rgb;
    food_eaten = fe; new_game = ng;
    exp_q.push_back(r ? 38'd0 : model(h, hs, hb, v, vs, vb, rgb));
    @(posedge pclk);
    #1;
    if (r) begin
      score_dec = 0; shown_m = '0; vprev_m = 1'b0;
    end else begin
      if (vs && !vprev_m) shown_m = bcd_of(score_dec);
      vprev_m = vs;
      if (ng) score_dec = 0;
      else if (fe && score_dec < 9999) score_dec++;
    end
    check("score", score_bcd, bcd_of(score_dec));
    if (exp_q.size() == 2) begin
      e = exp_q.pop_front();
      check("pipe", {hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out, rgb_out},
            r ? 38'd0 : e);
    end
  endtask

  task automatic idle(input logic fe, input logic ng);
    step(1'b0, 11'd700, 1'b0, 1'b0, 11'd500, 1'b0, 1'b0, 12'($urandom), fe, ng);
  endtask

  task automatic vs_pulse();
    step(1'b0, 11'd700, 1'b0, 1'b0, 11'd500, 1'b1, 1'b0, 12'($urandom), 1'b0, 1'b0);
    idle(1'b0, 1'b0);
  endtask

  task automatic scan_box(input logic hb);
    for (int v = Y - 2; v < Y + 34; v++)
      for (int h = X - 4; h < X + 68; h++)
        step(1'b0, 11'(h), 1'b0, hb, 11'(v), 1'b0, 1'b0, 12'($urandom), 1'b0, 1'b0);
  endtask

  initial begin
    font[0] = 128'h00007CC6C6CEDEF6E6C6C6C67C000000;
    font[1] = 128'h0000183878181818181818187E000000;
    font[2] = 128'h00007CC6060C183060C0C0C6FE000000;
    font[3] = 128'h00007CC606063C0606060606C67C0000;
    font[4] = 128'h00000C1C3C6CCCFE0C0C0C0C1E000000;
    font[5] = 128'h0000FEC0C0C0FC0606060606C67C0000;
    font[6] = 128'h00003860C0C0FCC6C6C6C6C67C000000;
    font[7] = 128'h0000FEC606060C183030303030000000;
    font[8] = 128'h00007CC6C6C67CC6C6C6C6C67C000000;
    font[9] = 128'h00007CC6C6C67E0606060606C0C78000;
    score_dec = 0; shown_m = '0; vprev_m = 1'b0;
    rst = 1'b1; hcount_in = '0; vcount_in = '0; hsync_in = 1'b0; hblnk_in = 1'b0;
    vsync_in = 1'b0; vblnk_in = 1'b0; rgb_in = '0; food_eaten = 1'b0; new_game = 1'b0;

    repeat (3) step(1'b1, 11'd0, 1'b0, 1'b0, 11'd0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
    check("reset_score", score_bcd, 16'h0000);
    check("reset_rgb", rgb_out, 12'h000);

    repeat (3) idle(1'b1, 1'b0);
    check("score_0003", score_bcd, 16'h0003);
    scan_box(1'b0);
    vs_pulse();
    scan_box(1'b0);

    idle(1'b0, 1'b1);
    repeat (99) idle(1'b1, 1'b0);
    check("score_0099", score_bcd, 16'h0099);
    idle(1'b1, 1'b0);
    check("score_0100", score_bcd, 16'h0100);

    idle(1'b0, 1'b1);
    repeat (9999) idle(1'b1, 1'b0);
    check("score_9999", score_bcd, 16'h9999);
    idle(1'b1, 1'b0);
    check("score_sat", score_bcd, 16'h9999);

    idle(1'b0, 1'b1);
    repeat (42) idle(1'b1, 1'b0);
    check("score_0042", score_bcd, 16'h0042);
    idle(1'b1, 1'b1);
    check("ng_wins", score_bcd, 16'h0000);

    repeat (1234) idle(1'b1, 1'b0);
    check("score_1234", score_bcd, 16'h1234);
    vs_pulse();
    scan_box(1'b0);
    for (int h = X; h < X + 24; h++)
      step(1'b0, 11'(h), 1'b0, 1'b1, 11'(Y + 6), 1'b0, 1'b0, 12'($urandom), 1'b0, 1'b0);

    for (int i = 0; i < 600; i++) begin
      step((i == 300 || i == 301) ? 1'b1 : 1'b0,
           11'($urandom_range(0, 100)), 1'($urandom), ($urandom_range(0, 7) == 0),
           11'($urandom_range(0, 60)), ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
           12'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 63) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
